// File: rtl/axi_pkg.sv
// AXI4 response codes and FSM state encodings shared by the memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package axi_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/axi_mem_array.sv
// Word array with one synchronous write port and one synchronous read-first read port.
// Latency: read data registered, valid 1 cycle after i_re; write lands at the clock edge.
// Backpressure: none; the read register holds its value while i_re is low.
module axi_mem_array #(
    parameter int DATA_W = 256,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Storage write; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read register; a same-cycle write to the same word returns the old value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory responder with independent read and write FSMs over one word array.
// Latency: first R beat 1 cycle after AR handshake; B 1 cycle after the final W handshake.
// Backpressure: R held stable until rready, B held until bready; one burst per channel in flight.
module axi_mem_slave
    import axi_pkg::*;
#(
    parameter int DATA_W   = 256,
    parameter int ADDR_W   = 40,
    parameter int DEPTH    = 1024,
    parameter int ADDR_LSB = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] axi_araddr,
    input  logic [7:0]        axi_arlen,
    input  logic              axi_arvalid,
    output logic              axi_arready,
    output logic [DATA_W-1:0] axi_rdata,
    output logic [1:0]        axi_rresp,
    output logic              axi_rlast,
    output logic              axi_rvalid,
    input  logic              axi_rready,
    input  logic [ADDR_W-1:0] axi_awaddr,
    input  logic [7:0]        axi_awlen,
    input  logic              axi_awvalid,
    output logic              axi_awready,
    input  logic [DATA_W-1:0] axi_wdata,
    input  logic              axi_wlast,
    input  logic              axi_wvalid,
    output logic              axi_wready,
    output logic [1:0]        axi_bresp,
    output logic              axi_bvalid,
    input  logic              axi_bready
);

    localparam int IDX_W = $clog2(DEPTH);

    // Read channel state
    rd_state_t        r_rstate, w_rstate_nxt;
    logic [IDX_W-1:0] r_ridx,   w_ridx_nxt;
    logic [7:0]       r_rlen,   w_rlen_nxt;
    logic [7:0]       r_rcnt,   w_rcnt_nxt;
    logic             r_rvalid, w_rvalid_nxt;
    logic             r_rlast,  w_rlast_nxt;
    logic             r_arready, w_arready_nxt;
    logic             w_mem_re;
    logic [IDX_W-1:0] w_mem_raddr;

    // Write channel state
    wr_state_t        r_wstate, w_wstate_nxt;
    logic [IDX_W-1:0] r_widx,   w_widx_nxt;
    logic [7:0]       r_wlen,   w_wlen_nxt;
    logic [7:0]       r_wcnt,   w_wcnt_nxt;
    logic             r_err,    w_err_nxt;
    logic             r_awready, w_awready_nxt;
    logic             r_wready, w_wready_nxt;
    logic             r_bvalid, w_bvalid_nxt;
    logic [1:0]       r_bresp,  w_bresp_nxt;
    logic             w_mem_we;
    logic             w_beat_err;

    // Address bits outside the word index are don't-care for this memory.
    logic w_unused;
    assign w_unused = &{1'b0,
                        axi_araddr[ADDR_W-1:ADDR_LSB+IDX_W], axi_araddr[ADDR_LSB-1:0],
                        axi_awaddr[ADDR_W-1:ADDR_LSB+IDX_W], axi_awaddr[ADDR_LSB-1:0]};

    axi_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_mem_we),
        .i_waddr (r_widx),
        .i_wdata (axi_wdata),
        .i_re    (w_mem_re),
        .i_raddr (w_mem_raddr),
        .o_rdata (axi_rdata)
    );

    // Read FSM next-state: fetch on AR accept, prefetch next word on each accepted non-last beat.
    always_comb begin
        w_rstate_nxt  = r_rstate;
        w_ridx_nxt    = r_ridx;
        w_rlen_nxt    = r_rlen;
        w_rcnt_nxt    = r_rcnt;
        w_rvalid_nxt  = r_rvalid;
        w_rlast_nxt   = r_rlast;
        w_arready_nxt = r_arready;
        w_mem_re      = 1'b0;
        w_mem_raddr   = r_ridx;
        case (r_rstate)
            R_IDLE: begin
                if (axi_arvalid) begin
                    w_ridx_nxt    = axi_araddr[ADDR_LSB +: IDX_W];
                    w_rlen_nxt    = axi_arlen;
                    w_rcnt_nxt    = 8'd0;
                    w_mem_re      = 1'b1;
                    w_mem_raddr   = axi_araddr[ADDR_LSB +: IDX_W];
                    w_rvalid_nxt  = 1'b1;
                    w_rlast_nxt   = (axi_arlen == 8'd0);
                    w_arready_nxt = 1'b0;
                    w_rstate_nxt  = R_DATA;
                end
            end
            R_DATA: begin
                if (axi_rready) begin
                    if (r_rlast) begin
                        w_rvalid_nxt  = 1'b0;
                        w_rlast_nxt   = 1'b0;
                        w_arready_nxt = 1'b1;
                        w_rstate_nxt  = R_IDLE;
                    end else begin
                        w_rcnt_nxt  = r_rcnt + 8'd1;
                        w_ridx_nxt  = r_ridx + 1'b1;
                        w_mem_re    = 1'b1;
                        w_mem_raddr = r_ridx + 1'b1;
                        w_rlast_nxt = ((r_rcnt + 8'd1) == r_rlen);
                    end
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rstate  <= R_IDLE;
            r_ridx    <= '0;
            r_rlen    <= 8'd0;
            r_rcnt    <= 8'd0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_ridx    <= w_ridx_nxt;
            r_rlen    <= w_rlen_nxt;
            r_rcnt    <= w_rcnt_nxt;
            r_rvalid  <= w_rvalid_nxt;
            r_rlast   <= w_rlast_nxt;
            r_arready <= w_arready_nxt;
        end
    end

    // A beat whose wlast disagrees with the counted length marks the burst as SLVERR.
    assign w_mem_we   = (r_wstate == W_DATA) && axi_wvalid && r_wready;
    assign w_beat_err = (axi_wlast != (r_wcnt == r_wlen));

    // Write FSM next-state: the counted length, not wlast, ends the burst.
    always_comb begin
        w_wstate_nxt  = r_wstate;
        w_widx_nxt    = r_widx;
        w_wlen_nxt    = r_wlen;
        w_wcnt_nxt    = r_wcnt;
        w_err_nxt     = r_err;
        w_awready_nxt = r_awready;
        w_wready_nxt  = r_wready;
        w_bvalid_nxt  = r_bvalid;
        w_bresp_nxt   = r_bresp;
        case (r_wstate)
            W_IDLE: begin
                if (axi_awvalid) begin
                    w_widx_nxt    = axi_awaddr[ADDR_LSB +: IDX_W];
                    w_wlen_nxt    = axi_awlen;
                    w_wcnt_nxt    = 8'd0;
                    w_err_nxt     = 1'b0;
                    w_awready_nxt = 1'b0;
                    w_wready_nxt  = 1'b1;
                    w_wstate_nxt  = W_DATA;
                end
            end
            W_DATA: begin
                if (w_mem_we) begin
                    w_widx_nxt = r_widx + 1'b1;
                    w_wcnt_nxt = r_wcnt + 8'd1;
                    w_err_nxt  = r_err | w_beat_err;
                    if (r_wcnt == r_wlen) begin
                        w_wready_nxt = 1'b0;
                        w_bvalid_nxt = 1'b1;
                        w_bresp_nxt  = w_err_nxt ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                        w_wstate_nxt = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (axi_bready) begin
                    w_bvalid_nxt  = 1'b0;
                    w_bresp_nxt   = AXI_RESP_OKAY;
                    w_awready_nxt = 1'b1;
                    w_wstate_nxt  = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Write FSM registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wstate  <= W_IDLE;
            r_widx    <= '0;
            r_wlen    <= 8'd0;
            r_wcnt    <= 8'd0;
            r_err     <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= AXI_RESP_OKAY;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_widx    <= w_widx_nxt;
            r_wlen    <= w_wlen_nxt;
            r_wcnt    <= w_wcnt_nxt;
            r_err     <= w_err_nxt;
            r_awready <= w_awready_nxt;
            r_wready  <= w_wready_nxt;
            r_bvalid  <= w_bvalid_nxt;
            r_bresp   <= w_bresp_nxt;
        end
    end

    assign axi_arready = r_arready;
    assign axi_rvalid  = r_rvalid;
    assign axi_rlast   = r_rlast;
    assign axi_rresp   = AXI_RESP_OKAY;
    assign axi_awready = r_awready;
    assign axi_wready  = r_wready;
    assign axi_bvalid  = r_bvalid;
    assign axi_bresp   = r_bresp;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed bench for axi_mem_slave: reset, single/burst writes and reads, stalls, SLVERR, wrap, concurrency.
// Latency: checks 1-cycle AR->R and W->B response timing.
// Backpressure: exercises rready stalls and bready handshakes.
module tb_axi_mem_slave;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 40;
    localparam int DEPTH  = 1024;
    localparam int LIMIT  = 100;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] axi_araddr;
    logic [7:0]        axi_arlen;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [DATA_W-1:0] axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rlast;
    logic              axi_rvalid;
    logic              axi_rready;
    logic [ADDR_W-1:0] axi_awaddr;
    logic [7:0]        axi_awlen;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [DATA_W-1:0] axi_wdata;
    logic              axi_wlast;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;

    int n_tests = 0;
    int n_fail  = 0;

    axi_mem_slave #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .ADDR_LSB (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .axi_araddr  (axi_araddr),
        .axi_arlen   (axi_arlen),
        .axi_arvalid (axi_arvalid),
        .axi_arready (axi_arready),
        .axi_rdata   (axi_rdata),
        .axi_rresp   (axi_rresp),
        .axi_rlast   (axi_rlast),
        .axi_rvalid  (axi_rvalid),
        .axi_rready  (axi_rready),
        .axi_awaddr  (axi_awaddr),
        .axi_awlen   (axi_awlen),
        .axi_awvalid (axi_awvalid),
        .axi_awready (axi_awready),
        .axi_wdata   (axi_wdata),
        .axi_wlast   (axi_wlast),
        .axi_wvalid  (axi_wvalid),
        .axi_wready  (axi_wready),
        .axi_bresp   (axi_bresp),
        .axi_bvalid  (axi_bvalid),
        .axi_bready  (axi_bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [ADDR_W-1:0] idx2addr(input int idx);
        logic [ADDR_W-1:0] a;
        a = ADDR_W'(idx) << 5;
        return a;
    endfunction

    // Write burst: beat i carries base+i; wlast raised only on beat last_beat.
    task automatic write_burst(input string tag, input int idx, input int len,
                               input logic [DATA_W-1:0] base, input int last_beat,
                               input logic [1:0] exp_resp);
        int n;
        axi_awaddr  = idx2addr(idx);
        axi_awlen   = 8'(len);
        axi_awvalid = 1'b1;
        n = 0;
        while (!axi_awready && n < LIMIT) begin step(); n++; end
        check({tag, "_aw_timeout"}, (n < LIMIT), 1'b1);
        step();
        axi_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            axi_wdata  = base + DATA_W'(i);
            axi_wlast  = (i == last_beat);
            axi_wvalid = 1'b1;
            n = 0;
            while (!axi_wready && n < LIMIT) begin step(); n++; end
            check({tag, "_w_timeout"}, (n < LIMIT), 1'b1);
            step();
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        check({tag, "_bvalid_lat1"}, axi_bvalid, 1'b1);
        check({tag, "_wready_drop"}, axi_wready, 1'b0);
        check({tag, "_bresp"}, axi_bresp, exp_resp);
        axi_bready = 1'b1;
        step();
        axi_bready = 1'b0;
        check({tag, "_bvalid_clr"}, axi_bvalid, 1'b0);
        check({tag, "_awready_back"}, axi_awready, 1'b1);
    endtask

    // Read burst expecting base+i on beat i (modulo wrap handled by caller's data);
    // rready held low for stall cycles on the first beat.
    task automatic read_burst(input string tag, input int idx, input int len,
                              input logic [DATA_W-1:0] base, input int stall);
        int n;
        axi_araddr  = idx2addr(idx);
        axi_arlen   = 8'(len);
        axi_arvalid = 1'b1;
        n = 0;
        while (!axi_arready && n < LIMIT) begin step(); n++; end
        check({tag, "_ar_timeout"}, (n < LIMIT), 1'b1);
        step();
        axi_arvalid = 1'b0;
        check({tag, "_rvalid_lat1"}, axi_rvalid, 1'b1);
        for (int i = 0; i <= len; i++) begin
            if (i == 0) begin
                for (int s = 0; s < stall; s++) begin
                    axi_rready = 1'b0;
                    step();
                    check({tag, "_stall_data"}, axi_rdata, base);
                    check({tag, "_stall_valid"}, axi_rvalid, 1'b1);
                end
            end
            axi_rready = 1'b1;
            check({tag, $sformatf("_b%0d_valid", i)}, axi_rvalid, 1'b1);
            check({tag, $sformatf("_b%0d_data", i)}, axi_rdata, base + DATA_W'(i));
            check({tag, $sformatf("_b%0d_last", i)}, axi_rlast, (i == len));
            check({tag, "_rresp"}, axi_rresp, 2'b00);
            step();
        end
        axi_rready = 1'b0;
        check({tag, "_rvalid_end"}, axi_rvalid, 1'b0);
        check({tag, "_arready_end"}, axi_arready, 1'b1);
    endtask

    initial begin
        rst_n       = 1'b0;
        axi_araddr  = '0;
        axi_arlen   = '0;
        axi_arvalid = 1'b0;
        axi_rready  = 1'b0;
        axi_awaddr  = '0;
        axi_awlen   = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wlast   = 1'b0;
        axi_wvalid  = 1'b0;
        axi_bready  = 1'b0;
        step(); step(); step();

        check("rst_arready", axi_arready, 1'b1);
        check("rst_awready", axi_awready, 1'b1);
        check("rst_rvalid",  axi_rvalid,  1'b0);
        check("rst_rlast",   axi_rlast,   1'b0);
        check("rst_rdata",   axi_rdata,   '0);
        check("rst_wready",  axi_wready,  1'b0);
        check("rst_bvalid",  axi_bvalid,  1'b0);
        check("rst_bresp",   axi_bresp,   2'b00);
        rst_n = 1'b1;
        step();

        // Single-beat write then readback at byte address 0x40 (idx 2).
        write_burst("wr1", 2, 0, 256'hA5, 0, 2'b00);
        read_burst("rd1", 2, 0, 256'hA5, 0);

        // Two-beat write to idx 0,1 then back-to-back and stalled reads.
        write_burst("wr2", 0, 1, 256'h100, 1, 2'b00);
        read_burst("rd2", 0, 1, 256'h100, 0);
        read_burst("rd2s", 0, 1, 256'h100, 3);

        // Early wlast on the second of three beats: all three land, SLVERR.
        write_burst("wrerr", 20, 2, 256'h200, 1, 2'b10);
        read_burst("rderr", 20, 2, 256'h200, 0);

        // Burst starting at the last word wraps to idx 0.
        write_burst("wrwrap", DEPTH-1, 1, 256'h300, 1, 2'b00);
        read_burst("rdwrap", DEPTH-1, 1, 256'h300, 0);

        // Read of idx 0 overlapping an unrelated write burst.
        fork
            read_burst("rdcc", 0, 0, 256'h301, 1);
            write_burst("wrcc", 10, 3, 256'h400, 3, 2'b00);
        join
        read_burst("rdcc2", 10, 3, 256'h400, 0);

        // Reset in the middle of a write burst aborts it with no B.
        axi_awaddr  = idx2addr(40);
        axi_awlen   = 8'd3;
        axi_awvalid = 1'b1;
        step();
        axi_awvalid = 1'b0;
        check("mid_wready", axi_wready, 1'b1);
        axi_wdata  = 256'h55;
        axi_wvalid = 1'b1;
        step();
        axi_wvalid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("mid_rst_wready",  axi_wready,  1'b0);
        check("mid_rst_awready", axi_awready, 1'b1);
        check("mid_rst_bvalid",  axi_bvalid,  1'b0);
        step(); step();
        check("mid_rst_bvalid2", axi_bvalid,  1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
- AXI4 memory responder: the slave end of the burst read/write interface that dma_engine initiates on.
- Backs the AR/R and AW/W/B channels with an on-chip word array.
- Serves INCR bursts. Used as the external-memory endpoint in DMA and system benches, and as a scratch memory behind the interconnect.
- Read and write channels run independent FSMs and may be active concurrently.

Parameters:
- DATA_W, 256, data bus width; one array word per beat.
- ADDR_W, 40, AXI byte-address width.
- DEPTH, 1024, array words; must be a power of two.
- ADDR_LSB, 5, log2(DATA_W/8); low byte-address bits ignored.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- axi_araddr  in  ADDR_W  read burst start byte address
- axi_arlen  in  8  beats-1
- axi_arvalid  in  1  AR valid
- axi_arready  out  1  AR ready
- axi_rdata  out  DATA_W  read data
- axi_rresp  out  2  always 2'b00
- axi_rlast  out  1  final beat of burst
- axi_rvalid  out  1  R valid
- axi_rready  in  1  R ready
- axi_awaddr  in  ADDR_W  write burst start byte address
- axi_awlen  in  8  beats-1
- axi_awvalid  in  1  AW valid
- axi_awready  out  1  AW ready
- axi_wdata  in  DATA_W  write data
- axi_wlast  in  1  master's last-beat flag
- axi_wvalid  in  1  W valid
- axi_wready  out  1  W ready
- axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- axi_bvalid  out  1  B valid
- axi_bready  in  1  B ready

Behaviour:
- Reset (rst_n=0 at posedge clk): both FSMs go IDLE.
  - Outputs: arready=1, awready=1, rvalid=0, rlast=0, rdata=0, rresp=0, wready=0, bvalid=0, bresp=0.
  - Array contents are not reset.
  - A reset mid-burst aborts the burst immediately; no B or R completion is issued.
- Index: idx = addr[ADDR_LSB +: log2(DEPTH)]. Increments by 1 per beat and wraps modulo DEPTH; no error is raised on wrap.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE, arready=1. On arvalid: latch idx and len, set rcnt=0, load rdata <= mem[idx], rvalid<=1, rlast<=(arlen==0), arready<=0.
  - First rvalid is 1 cycle after AR handshake.
  - R_DATA: rvalid, rdata and rlast are held stable until rready.
  - On rready with rcnt<len: rcnt++, idx++, rdata<=mem[idx+1], rlast<=(rcnt+1==len). rvalid stays 1, giving back-to-back beats.
  - On rready with rlast: rvalid<=0, rlast<=0, arready<=1, return to R_IDLE. A new AR is accepted no earlier than the following cycle.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE, awready=1. On awvalid: latch idx and len, set wcnt=0, clear err, awready<=0, wready<=1.
  - W_DATA: on wvalid&&wready, mem[idx]<=wdata, idx++, wcnt++.
    - err<=1 if wlast != (wcnt==len).
    - The burst ends on the beat where wcnt==len, regardless of wlast: wready<=0, bvalid<=1, bresp<=err_next?2'b10:2'b00. Enter W_RESP.
  - W_RESP: bvalid held until bready, then bvalid<=0, bresp<=0, awready<=1, return to W_IDLE.
- Read/write same word in same cycle: the read register captures the pre-write value (read-first). The write lands.
- Full 256-beat bursts (len=255) are supported; counters are 8 bits with no overflow at len=255.

Decomposition:
- Shared package axi_pkg: AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10, AXI_RESP_DECERR=2'b11, plus the read/write FSM state enums.
- One sub-module, axi_mem_array: DEPTH x DATA_W, one synchronous write port and one synchronous read-first read port.
- The FSMs and beat counters stay in axi_mem_slave.

Test Plan:
- Reset with all inputs 0 -> arready=1, awready=1, rvalid=0, wready=0, bvalid=0, rdata=0.
- AW addr 0x40, len=0, W data 0xA5 with wlast=1, bready=1 -> bvalid 1 cycle after W handshake with bresp=00. Then AR 0x40, len=0 -> rvalid next cycle, rdata=0xA5, rlast=1.
- Write 0x100/0x101 to idx 0,1. Then AR addr 0, len=1, rready=1 (dma_engine cols=2 case) -> two consecutive rvalid beats 0x100 then 0x101; rlast only on the 2nd beat; arready=1 the cycle after.
- Same 2-beat read with rready low for 3 cycles on beat 1 -> rdata=0x100 held stable, no beat lost or duplicated.
- AW len=2 with wlast asserted on beat 2 -> 3 beats accepted, then bresp=2'b10. Length of 3 writes is confirmed by readback.
- AW idx DEPTH-1, len=1 -> second beat written to idx 0. Then AR to idx 0 concurrently with an unrelated write burst -> both complete with correct data.
